// File: rtl/wb_master_bridge.sv
// Wishbone classic master bridging a valid/ready request stream to single-beat bus cycles.
// Requests are queued in a small FIFO; one bus cycle is in flight and responses come back in order.
module wb_master_bridge #(
  parameter int unsigned REQ_FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rstn_i,
  // request stream
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  // response stream
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  // Wishbone master port
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_ms_o,
  input  logic [31:0] wb_dat_sm_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned PtrW = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned EntW = 65;
  localparam logic [PtrW:0]   FifoFull  = (PtrW + 1)'(REQ_FIFO_DEPTH);
  localparam logic [CntW-1:0] CntLast   = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax    = '1;
  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [EntW-1:0] fifo_mem_q [REQ_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            push, pop, full, empty;
  logic [EntW-1:0] head;

  assign full        = (count_q == FifoFull);
  assign empty       = (count_q == '0);
  assign req_ready_o = rstn_i & ~full;
  assign push        = req_valid_i & req_ready_o;
  assign head        = fifo_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {req_we_i, req_adr_i, req_dat_i};
  end

  // ---------------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_to_q, rsp_to_d;
  logic            launch;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    rsp_to_d  = rsp_to_q;
    launch    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) launch = 1'b1;
      end
      StBus: begin
        if (wb_err_i) begin
          rsp_err_d = 1'b1;
          rsp_to_d  = 1'b0;
          rsp_dat_d = '0;
          cyc_d     = 1'b0;
          state_d   = StResp;
        end else if (wb_ack_i) begin
          rsp_err_d = 1'b0;
          rsp_to_d  = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : wb_dat_sm_i;
          cyc_d     = 1'b0;
          state_d   = StResp;
        end else begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          // cnt_q holds the number of BUS cycles already elapsed before this one.
          if (TimeoutEn && (cnt_q == CntLast)) begin
            rsp_to_d  = 1'b1;
            rsp_err_d = 1'b0;
            rsp_dat_d = '0;
            cyc_d     = 1'b0;
            state_d   = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          if (!empty) launch = 1'b1;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      we_d    = head[64];
      adr_d   = head[63:32];
      dat_d   = head[31:0];
      cyc_d   = 1'b1;
      cnt_d   = '0;
      state_d = StBus;
    end
  end

  assign pop = launch;

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      rsp_to_q  <= rsp_to_d;
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_ms_o   = dat_q;

  assign rsp_valid_o   = (state_q == StResp);
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;
  assign busy_o        = (state_q != StIdle) | ~empty;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with a behavioural Wishbone slave (configurable wait/err/silent).
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_to, busy;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;

  always #5 clk = ~clk;

  wb_master_bridge #(
    .REQ_FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rstn_i       (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_adr_i    (req_adr),
    .req_dat_i    (req_dat),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_to),
    .busy_o       (busy),
    .wb_cyc_o     (wb_cyc),
    .wb_stb_o     (wb_stb),
    .wb_we_o      (wb_we),
    .wb_adr_o     (wb_adr),
    .wb_dat_ms_o  (wb_dat_ms),
    .wb_dat_sm_i  (wb_dat_sm),
    .wb_ack_i     (wb_ack),
    .wb_err_i     (wb_err)
  );

  // Behavioural slave: acks after slv_delay wait cycles, errs for adr > 0x10 (with ack too).
  logic [31:0] slv_mem [16];
  logic        slv_init, slv_silent, slv_hit;
  int          slv_delay;
  int          wcnt = 0;

  assign slv_hit   = wb_cyc && wb_stb && !slv_silent && (wcnt == slv_delay);
  assign wb_ack    = slv_hit;
  assign wb_err    = slv_hit && (wb_adr > 32'h10);
  assign wb_dat_sm = slv_mem[wb_adr[5:2]];

  always @(posedge clk) begin
    if (slv_init) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (wb_ack && !wb_err && wb_we) begin
      slv_mem[wb_adr[5:2]] <= wb_dat_ms;
    end
    if (wb_cyc && wb_stb && !wb_ack && !wb_err) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int t = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    while (!req_ready && t < 50) begin
      tick();
      t++;
    end
    if (!req_ready) check("push_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          delay;
    logic        silent;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_to;
    int          exp_cyc;
  } vec_t;

  task automatic do_txn(input vec_t v, input string tag);
    int          cyc_n = 0;
    int          t = 0;
    logic        seen_we = 1'b0;
    logic [31:0] seen_adr = '0;
    logic [31:0] seen_dat = '0;
    slv_delay  = v.delay;
    slv_silent = v.silent;
    push(v.we, v.adr, v.dat);
    while (!rsp_valid && t < 40) begin
      if (wb_cyc) begin
        cyc_n++;
        seen_we  = wb_we;
        seen_adr = wb_adr;
        seen_dat = wb_dat_ms;
      end
      tick();
      t++;
    end
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, "_dat"}, rsp_dat, v.exp_dat);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
    check({tag, "_timeout"}, {31'b0, rsp_to}, {31'b0, v.exp_to});
    check({tag, "_cyc_len"}, 32'(cyc_n), 32'(v.exp_cyc));
    check({tag, "_wb_we"}, {31'b0, seen_we}, {31'b0, v.we});
    check({tag, "_wb_adr"}, seen_adr, v.adr);
    if (v.we) check({tag, "_wb_dat_ms"}, seen_dat, v.dat);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
    slv_silent = 1'b0;
  endtask

  vec_t        vecs [10];
  logic [31:0] bp_adr [6];
  logic [31:0] bp_exp [6];
  logic [31:0] bp_got [6];

  initial begin
    int t;
    int n;
    int acc;
    logic pend;
    logic saw;

    vecs[0] = '{1'b1, 32'h00, 32'h0000_00FF,     0, 1'b0, 32'h0,         1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h00, 32'h0,             0, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1};
    vecs[2] = '{1'b0, 32'h14, 32'h0,             0, 1'b0, 32'h0,         1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h00, 32'h0,             2, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h08, 32'h0,             0, 1'b1, 32'h0,         1'b0, 1'b1, 8};
    vecs[5] = '{1'b0, 32'h08, 32'h0,             7, 1'b0, 32'hA500_0002, 1'b0, 1'b0, 8};
    vecs[6] = '{1'b1, 32'h0C, 32'h1234_5678,     1, 1'b0, 32'h0,         1'b0, 1'b0, 2};
    vecs[7] = '{1'b0, 32'h0C, 32'h0,             0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1};
    vecs[8] = '{1'b1, 32'h20, 32'hDEAD_BEEF,     0, 1'b0, 32'h0,         1'b1, 1'b0, 1};
    vecs[9] = '{1'b0, 32'h10, 32'h0,             0, 1'b0, 32'hA500_0004, 1'b0, 1'b0, 1};

    bp_adr = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h00};
    bp_exp = '{32'h0000_00FF, 32'hA500_0001, 32'hA500_0002, 32'h1234_5678,
               32'hA500_0004, 32'h0000_00FF};

    rstn = 1'b0; slv_init = 1'b1; slv_silent = 1'b0; slv_delay = 0;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; rsp_ready = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_stb", {31'b0, wb_stb}, 32'd0);
    check("rst_we", {31'b0, wb_we}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat_ms", wb_dat_ms, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_to", {31'b0, rsp_to}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    slv_init = 1'b0;
    rstn = 1'b1;
    tick();

    // Latency: accepted in T, cyc in T+2, response in T+3
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h04; req_dat = '0;
    check("lat_ready_T", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("lat_cyc_T1", {31'b0, wb_cyc}, 32'd0);
    check("lat_busy_T1", {31'b0, busy}, 32'd1);
    tick();
    check("lat_cyc_T2", {31'b0, wb_cyc}, 32'd1);
    check("lat_stb_T2", {31'b0, wb_stb}, 32'd1);
    check("lat_rsp_T2", {31'b0, rsp_valid}, 32'd0);
    tick();
    check("lat_rsp_T3", {31'b0, rsp_valid}, 32'd1);
    check("lat_dat_T3", rsp_dat, 32'hA500_0001);
    check("lat_err_T3", {31'b0, rsp_err}, 32'd0);
    check("lat_to_T3", {31'b0, rsp_to}, 32'd0);
    check("lat_cyc_T3", {31'b0, wb_cyc}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Backpressure: 1 in flight + 4 buffered, 6th waits
    slv_delay = 0; rsp_ready = 1'b0;
    acc = 0; t = 0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = bp_adr[0];
    while (acc < 5 && t < 40) begin
      if (req_ready) begin
        acc++;
        tick();
        req_adr = bp_adr[acc];
      end else begin
        tick();
      end
      t++;
    end
    check("bp_accepted", 32'(acc), 32'd5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_full_%0d", k), {31'b0, req_ready}, 32'd0);
      check($sformatf("bp_hold_valid_%0d", k), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp_hold_dat_%0d", k), rsp_dat, bp_exp[0]);
      tick();
    end
    rsp_ready = 1'b1;
    n = 0; t = 0;
    for (int k = 0; k < 6; k++) bp_got[k] = '0;
    while (n < 6 && t < 60) begin
      pend = req_valid && req_ready;
      if (rsp_valid) begin
        bp_got[n] = rsp_dat;
        n++;
      end
      tick();
      t++;
      if (pend) req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("bp_rsp_count", 32'(n), 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("bp_rsp_%0d", k), bp_got[k], bp_exp[k]);

    // Reset in the middle of a bus cycle with one more request queued
    slv_delay = 3;
    push(1'b0, 32'h04, 32'h0);
    push(1'b0, 32'h08, 32'h0);
    t = 0;
    while (!wb_cyc && t < 10) begin
      tick();
      t++;
    end
    check("mid_in_bus", {31'b0, wb_cyc}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_ready_low", {31'b0, req_ready}, 32'd0);
    tick();
    rstn = 1'b1;
    check("mid_cyc", {31'b0, wb_cyc}, 32'd0);
    check("mid_stb", {31'b0, wb_stb}, 32'd0);
    check("mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (wb_cyc || rsp_valid || busy) saw = 1'b1;
      tick();
    end
    check("mid_quiet", {31'b0, saw}, 32'd0);
    do_txn('{1'b0, 32'h08, 32'h0, 0, 1'b0, 32'hA500_0002, 1'b0, 1'b0, 1}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone master that turns a simple valid/ready request stream into classic single-beat Wishbone cycles on a wb_bus_t master port.
- Returns one response per request, in request order.
- Sits between a processor/DMA-side request source and Wishbone slaves such as gpio_module.
- Buffers requests in a small FIFO, runs one bus cycle at a time, and converts missing acks into timeout responses.

Parameters:
REQ_FIFO_DEPTH, 4, request FIFO entries; power of 2, >= 2.
TIMEOUT_CYCLES, 256, max cycles a bus cycle may stay open without ack/err; 0 disables the timeout.

Ports:
clk  input  1  clock, all logic on rising edge
rstn_i  input  1  synchronous reset, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  FIFO can accept a request
req_we_i  input  1  1 = write, 0 = read
req_adr_i  input  32  byte address, passed unmodified
req_dat_i  input  32  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed
rsp_dat_o  output  32  read data; 0 for writes, errors and timeouts
rsp_err_o  output  1  slave signalled wb_err
rsp_timeout_o  output  1  no ack/err within TIMEOUT_CYCLES
busy_o  output  1  FSM not IDLE or FIFO non-empty
wb_bus  interface  -  wb_bus_t.master; drives wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms; samples wb_dat_sm, wb_ack, wb_err

Behaviour:
- Reset, synchronous: rstn_i low at a clock edge forces the following, regardless of state.
  - FSM goes to IDLE; FIFO is emptied; timeout counter cleared.
  - wb_cyc, wb_stb, wb_we = 0; wb_adr, wb_dat_ms = 0.
  - rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; rsp_dat_o = 0; busy_o = 0.
  - req_ready_o = 0 while rstn_i is low.
- Reset mid-bus-cycle: cyc/stb drop in the cycle after the sampling edge. The in-flight request is discarded and produces no response.
- FIFO rules:
  - Push on req_valid_i & req_ready_o; req_ready_o = !full.
  - No push-through-when-full, even if a pop happens in the same cycle.
  - No bypass: a pushed entry is visible to the FSM the following cycle.
- FSM states: IDLE, BUS, RESP. All Wishbone outputs are registered.
- IDLE:
  - If the FIFO is non-empty: pop the head, load adr/dat/we into the bus registers, set cyc=stb=1, clear the counter, go to BUS.
- BUS (cyc=stb=1, wb_we per request):
  - Each cycle, sample wb_ack/wb_err.
  - If wb_err: rsp_err=1, rsp_dat=0. wb_err takes precedence over wb_ack; slaves assert both together.
  - Else if wb_ack: rsp_err=0; rsp_dat = wb_dat_sm for reads, 0 for writes.
  - Either case: cyc=stb=0 at the edge, go to RESP.
  - Else increment the counter. If TIMEOUT_CYCLES != 0 and the BUS state has lasted TIMEOUT_CYCLES cycles: rsp_timeout=1, rsp_err=0, rsp_dat=0, drop cyc/stb, go to RESP.
  - An ack on the final allowed cycle wins over the timeout.
  - Combinational-ack slaves complete in one BUS cycle.
- RESP:
  - rsp_valid_o=1; rsp_dat/err/timeout held stable until rsp_ready_i.
  - On rsp_ready_i: clear rsp_valid at the edge. If the FIFO is non-empty, pop and go directly to BUS; else go to IDLE.
- Exactly one outstanding transaction; responses are in request order.
- Latency: request accepted in cycle T → cyc/stb high in T+2 → with a same-cycle ack, rsp_valid_o high in T+3.
- Throughput: sustained rate is 1 transaction per 2 cycles with rsp_ready_i=1 and a zero-wait slave.
- Counter width: clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
- busy_o is combinational from state and FIFO count.

Test Plan:
- Latency: behavioural zero-wait slave; accept read of 0x00000004 at cycle T → cyc/stb high exactly in T+2; rsp_valid_o in T+3 with rsp_dat_o = slave word, err=0, timeout=0.
- Write/read-back: write 0x000000FF to 0x00, then read 0x00 → first rsp_dat_o=0, second rsp_dat_o=0x000000FF. wb_we is 1 then 0, and wb_dat_ms=0x000000FF during the write.
- Error: slave errs for adr>0x10; read 0x14 → rsp_err_o=1, rsp_dat_o=0, rsp_timeout_o=0. A following read of 0x00 completes normally.
- Timeout: TIMEOUT_CYCLES=8, slave never responds → cyc high exactly 8 cycles, then rsp_timeout_o=1, rsp_err_o=0. Repeat with ack on cycle 8 → normal response, timeout=0.
- Backpressure: rsp_ready_i=0, push 6 requests → 1 in flight + 4 buffered, so req_ready_o falls after the 5th accept. Response 1 stays stable while stalled. Releasing rsp_ready_i yields 5 responses in order; the 6th request is then accepted and completes.
- Reset mid-cycle: slave with 3-cycle ack delay; rstn_i low for 1 cycle during BUS → cyc/stb=0, rsp_valid=0, req_ready=0 next cycle. After release the FIFO is empty and no bus cycle starts until a new request arrives.
